// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path (and the future transmit path).
//   rx_state_t      : receiver FSM state encoding
//   OVERSAMPLE_DEF  : default sample ticks per bit
//   expected_parity : parity bit a transmitter would send for a data word
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam int OVERSAMPLE_DEF = 16;

  // XOR of the low nbits of data; odd parity inverts the result.
  function automatic logic expected_parity(input logic [8:0] data,
                                           input int         nbits,
                                           input logic       odd);
    logic p;
    p = odd;
    for (int i = 0; i < 9; i++) begin
      if (i < nbits) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Read-side method handshake of the UART receiver.
//   EN_get  : consumer pops the FIFO head (honoured only while RDY_get=1)
//   get     : FIFO head word
//   RDY_get : FIFO not empty
//   count   : FIFO occupancy
// master = consumer (register block), slave = receiver.
interface uart_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic                 EN_get;
  logic [DATA_BITS-1:0] get;
  logic                 RDY_get;
  logic [CNT_W-1:0]     count;

  modport master (output EN_get, input get, input RDY_get, input count);
  modport slave  (input EN_get, output get, output RDY_get, output count);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO shared by the UART receive and transmit paths.
//   push/push_data/full : write side; a push while full is ignored unless a
//                         pop happens in the same cycle
//   pop/head/empty      : read side; head is the registered oldest entry
//   count               : occupancy
// DEPTH must be a power of 2 so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with oversampled start/data/parity/stop detection and a
// receive FIFO drained through a get/RDY_get method handshake.
//   CLK, RST_N    : clock, asynchronous active-low reset
//   rx_in         : raw serial line (idle high, asynchronous to CLK)
//   baud_div      : CLK cycles per sample tick minus 1 (change only in IDLE)
//   rx_if         : get/RDY_get/EN_get/count handshake (slave side)
//   frame_err     : sticky, stop bit sampled low
//   parity_err    : sticky, parity mismatch
//   overrun_err   : sticky, word dropped on a full FIFO
//   EN_clear_err  : clears the sticky flags (a same-cycle set wins)
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  rx_in,
  input  logic [15:0]           baud_div,
  uart_rx_fifo_if.slave         rx_if,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  overrun_err,
  input  logic                  EN_clear_err
);

  localparam int SC_W  = $clog2(OVERSAMPLE);
  localparam int BC_W  = $clog2(DATA_BITS);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic                 rx_m, rx_s;
  logic [15:0]          tick_cnt;
  logic                 tick;
  rx_state_t            state;
  logic [SC_W-1:0]      sc;
  logic [BC_W-1:0]      bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
  logic                 mid_start, bit_end, stop_sample;
  logic                 push, pop, frame_set, parity_set, overrun_set;
  logic                 fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_head;
  logic [CNT_W-1:0]     fifo_count;

  // ---- synchroniser: two flops, reset to the idle-high line level ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_in;
      rx_s <= rx_m;
    end
  end

  // ---- sample tick generator ----
  // >= rather than == so a divider lowered while idle cannot strand the
  // counter above the new wrap point.
  assign tick = (tick_cnt >= baud_div);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 16'd1;
  end

  // ---- frame FSM: sc counts ticks within the current bit ----
  // Start is confirmed half a bit after the falling edge; every later sample
  // is a full bit further on, so all samples land at mid-bit.
  assign mid_start   = (sc == SC_W'(OVERSAMPLE / 2 - 1));
  assign bit_end     = (sc == SC_W'(OVERSAMPLE - 1));
  assign stop_sample = (state == STOP) && tick && bit_end;
  assign push        = stop_sample && rx_s && !par_bad;
  assign frame_set   = stop_sample && !rx_s;
  assign parity_set  = stop_sample && rx_s && par_bad;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      sc      <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
    end else begin
      case (state)
        IDLE: if (tick && !rx_s) begin
          state   <= START;
          sc      <= '0;
          par_bad <= 1'b0;
        end
        START: if (tick) begin
          if (mid_start) begin
            sc      <= '0;
            bit_cnt <= '0;
            state   <= rx_s ? IDLE : DATA;   // high at mid-start is a glitch
          end else sc <= sc + SC_W'(1);
        end
        DATA: if (tick) begin
          if (bit_end) begin
            sc      <= '0;
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};   // LSB arrives first
            bit_cnt <= bit_cnt + BC_W'(1);
            if (bit_cnt == BC_W'(DATA_BITS - 1))
              state <= (PARITY_EN != 0) ? PARITY : STOP;
          end else sc <= sc + SC_W'(1);
        end
        PARITY: if (tick) begin
          if (bit_end) begin
            sc      <= '0;
            par_bad <= (rx_s != expected_parity(9'(shreg), DATA_BITS, PARITY_ODD != 0));
            state   <= STOP;
          end else sc <= sc + SC_W'(1);
        end
        STOP: if (tick) begin
          if (bit_end) begin
            sc    <= '0;
            state <= rx_s ? IDLE : WAIT_IDLE;
          end else sc <= sc + SC_W'(1);
        end
        WAIT_IDLE: if (rx_s) state <= IDLE;   // hold off through a break
        default: state <= IDLE;
      endcase
    end
  end

  // ---- receive FIFO ----
  assign pop         = rx_if.EN_get && !fifo_empty;
  assign overrun_set = push && fifo_full && !pop;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .push      (push),
    .push_data (shreg),
    .full      (fifo_full),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rx_if.get     = fifo_head;
  assign rx_if.RDY_get = !fifo_empty;
  assign rx_if.count   = fifo_count;

  // ---- sticky error flags ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= frame_set   || (frame_err   && !EN_clear_err);
      parity_err  <= parity_set  || (parity_err  && !EN_clear_err);
      overrun_err <= overrun_set || (overrun_err && !EN_clear_err);
    end
  end

endmodule
